// File: rtl/sample_serializer.sv
// Sample serializer: buffers 12-bit decimated samples in a small FIFO and
// shifts each one out MSB first with a divided bit clock and a frame sync.
module sample_serializer #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              data_in,
  input  logic                     new_data,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     fs,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int DCW  = $clog2(DIV);
  localparam int HALF = DIV / 2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state;
  logic [11:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [10:0]      shreg;
  logic [DCW-1:0]   div_cnt;
  logic [3:0]       bit_cnt;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic have_data;

  assign full      = (fifo_level == LW'(DEPTH));
  assign have_data = (fifo_level != '0);
  assign pop       = (state == LOAD);
  // A full FIFO still accepts a sample when the head is popped in the same cycle.
  assign push      = new_data && (!full || pop);
  assign drop      = new_data && full && !pop;

  // NOTE: sample storage has no reset; emptiness is defined by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // A new drop wins over a coincident clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      fs      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk  <= 1'b0;
          sdata <= 1'b0;
          fs    <= 1'b0;
          if (enable && have_data) state <= LOAD;
        end
        LOAD: begin
          // Outputs are registered here so the MSB appears in the first SHIFT cycle.
          shreg   <= mem[rd_ptr][10:0];
          sdata   <= mem[rd_ptr][11];
          fs      <= 1'b1;
          sclk    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= 4'd11;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DCW'(DIV - 1)) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            fs      <= 1'b0;
            if (bit_cnt == 4'd0) begin
              sdata <= 1'b0;
              state <= (enable && have_data) ? LOAD : IDLE;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              sdata   <= shreg[10];
              shreg   <= {shreg[9:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            sclk    <= (div_cnt >= DCW'(HALF - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: stimulus queues expected words, a
// monitor deserializes sdata on sclk rising edges and compares in order.
module tb_sample_serializer;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic [11:0]            data_in;
  logic                   new_data;
  logic                   enable;
  logic                   clr_ovf;
  logic                   sclk;
  logic                   sdata;
  logic                   fs;
  logic                   overflow;
  logic [$clog2(DEPTH):0] fifo_level;

  sample_serializer #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .new_data   (new_data),
    .enable     (enable),
    .clr_ovf    (clr_ovf),
    .sclk       (sclk),
    .sdata      (sdata),
    .fs         (fs),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [11:0] exp_q[$];
  int          starts[$];
  bit          in_word = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling clk edge, away from the DUT update edge.
  initial begin
    logic        prev_sclk;
    logic [11:0] word;
    int          nbits;
    int          fs_cnt;
    prev_sclk = 1'b0;
    word      = '0;
    nbits     = 0;
    fs_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_word   = 1'b0;
        prev_sclk = 1'b0;
      end else begin
        if (!in_word && fs) begin
          in_word = 1'b1;
          nbits   = 0;
          fs_cnt  = 0;
          word    = '0;
          starts.push_back(cyc);
        end
        if (in_word) begin
          if (fs) fs_cnt++;
          if (sclk && !prev_sclk) begin
            word = {word[10:0], sdata};
            nbits++;
            if (nbits == 12) begin
              check("fs_width", 32'(fs_cnt), 32'(DIV));
              if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got %03h expected none", word);
              end else begin
                check("word", 32'(word), 32'(exp_q.pop_front()));
              end
              in_word = 1'b0;
            end
          end
        end
        prev_sclk = sclk;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] d);
    data_in  = d;
    new_data = 1'b1;
    tick(1);
    new_data = 1'b0;
  endtask

  task automatic wait_fs(input int bound);
    for (int i = 0; i < bound && !fs; i++) tick(1);
    check("fs_seen", 32'(fs), 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || in_word); i++) tick(1);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sclk"},  32'(sclk),  32'd0);
    check({tag, "_sdata"}, 32'(sdata), 32'd0);
    check({tag, "_fs"},    32'(fs),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b1;
    data_in  = '0;
    new_data = 1'b0;
    enable   = 1'b0;
    clr_ovf  = 1'b0;

    // Reset state, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst");
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single word 0xA5C: first SHIFT cycle at N+3, then 48 SHIFT cycles.
    enable = 1'b1;
    exp_q.push_back(12'hA5C);
    strobe(12'hA5C);
    check("n1_fs",    32'(fs), 32'd0);
    check("n1_level", 32'(fifo_level), 32'd1);
    tick(1);
    check("n2_fs",    32'(fs), 32'd0);
    tick(1);
    check("n3_fs",    32'(fs),    32'd1);
    check("n3_sdata", 32'(sdata), 32'd1);
    check("n3_sclk",  32'(sclk),  32'd0);
    tick(2);
    check("n5_sclk",  32'(sclk),  32'd1);
    tick(2);
    check("n7_sclk",  32'(sclk),  32'd0);
    check("n7_fs",    32'(fs),    32'd0);
    check("n7_sdata", 32'(sdata), 32'd0);
    tick(44);
    check_idle_outputs("after_word");
    check("after_word_level", 32'(fifo_level), 32'd0);
    wait_drain(20);

    // Overflow with enable low, then clear handling including the race.
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(12'(i));
      strobe(12'(i));
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_set",   32'(overflow),   32'd1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    strobe(12'h006);
    clr_ovf = 1'b0;
    check("ovf_race",       32'(overflow),   32'd1);
    check("ovf_race_level", 32'(fifo_level), 32'd4);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);
    starts.delete();
    enable = 1'b1;
    wait_drain(400);
    check("ovf_words", 32'(starts.size()), 32'd4);
    for (int i = 1; i < starts.size(); i++)
      check("period", 32'(starts[i] - starts[i-1]), 32'(12 * DIV + 1));
    check("ovf_end_level", 32'(fifo_level), 32'd0);

    // Full FIFO with a push coincident with the LOAD pop.
    enable = 1'b0;
    tick(2);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(12'(i * 12'h111));
      strobe(12'(i * 12'h111));
    end
    enable = 1'b1;
    tick(1);
    exp_q.push_back(12'h555);
    strobe(12'h555);
    check("fullpop_level", 32'(fifo_level), 32'd4);
    check("fullpop_ovf",   32'(overflow),   32'd0);
    check("fullpop_fs",    32'(fs),         32'd1);
    wait_drain(400);
    tick(2);
    check("fullpop_end_level", 32'(fifo_level), 32'd0);

    // Enable dropped during bit 6: word completes, next word is held.
    enable = 1'b0;
    exp_q.push_back(12'h0F0);
    strobe(12'h0F0);
    strobe(12'h32F);
    enable = 1'b1;
    wait_fs(10);
    tick(21);
    enable = 1'b0;
    tick(30);
    check("drop_level", 32'(fifo_level), 32'd1);
    check_idle_outputs("drop");
    check("drop_done",  32'(exp_q.size()), 32'd0);
    n = starts.size();
    tick(20);
    check("drop_no_start", 32'(starts.size()), 32'(n));

    // Reset during bit 3 of 0x32F with one more sample queued.
    exp_q.push_back(12'h32F);
    enable = 1'b1;
    wait_fs(10);
    tick(1);
    strobe(12'h777);
    tick(32);
    check("prerst_sclk",  32'(sclk),       32'd1);
    check("prerst_sdata", 32'(sdata),      32'd1);
    check("prerst_level", 32'(fifo_level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_level", 32'(fifo_level), 32'd0);
    exp_q.delete();
    tick(3);
    rst_n = 1'b1;
    starts.delete();
    tick(60);
    check("postrst_words", 32'(starts.size()), 32'd0);
    check("postrst_level", 32'(fifo_level),    32'd0);
    check_idle_outputs("postrst");

    // First push accepted on the first edge after reset release.
    enable = 1'b0;
    rst_n  = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    data_in  = 12'hABC;
    new_data = 1'b1;
    @(posedge clk);
    #1 new_data = 1'b0;
    check("first_push_level", 32'(fifo_level), 32'd1);
    exp_q.push_back(12'hABC);
    enable = 1'b1;
    wait_drain(100);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
